// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display scanner.
package display_pkg;

    typedef logic [0:0] state_t;

    localparam state_t BLANK = 1'b0;
    localparam state_t SHOW  = 1'b1;

    localparam logic [6:0] SEG_OFF  = 7'h7F;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [1:0] DIG_MIN_ONES = 2'd0;
    localparam logic [1:0] DIG_MIN_TENS = 2'd1;
    localparam logic [1:0] DIG_HR_ONES  = 2'd2;
    localparam logic [1:0] DIG_HR_TENS  = 2'd3;

endpackage

// File: rtl/bcd_to_7seg.sv
// BCD nibble to active-low {g,f,e,d,c,b,a} cathode pattern; non-BCD codes show a dash.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = SEG_DASH;
        case (bcd)
            4'd0: seg_c = 7'b1000000;
            4'd1: seg_c = 7'b1111001;
            4'd2: seg_c = 7'b0100100;
            4'd3: seg_c = 7'b0110000;
            4'd4: seg_c = 7'b0011001;
            4'd5: seg_c = 7'b0010010;
            4'd6: seg_c = 7'b0000010;
            4'd7: seg_c = 7'b1111000;
            4'd8: seg_c = 7'b0000000;
            4'd9: seg_c = 7'b0010000;
            default: seg_c = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Four-digit multiplexed seven-segment scanner with inter-digit blanking and
// a per-frame snapshot of the displayed time.
module display_scan_controller
    import display_pkg::*;
#(
    parameter int unsigned DIGIT_CYCLES = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [15:0] digits,
    input  logic        pm,
    input  logic        colon_on,
    output logic [1:0]  digit_sel,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic [15:0]      snap_q, snap_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             frame_done_q, frame_done_d;
    logic             frozen_q, frozen_d;

    logic [3:0]       nibble_c;
    logic [6:0]       dec_seg_c;
    logic [6:0]       seg_pat_c;
    logic             dp_pat_c;

    // Nibble of the frame snapshot belonging to the active digit
    always_comb begin
        nibble_c = snap_q[3:0];
        case (digit_sel_q)
            DIG_MIN_ONES: nibble_c = snap_q[3:0];
            DIG_MIN_TENS: nibble_c = snap_q[7:4];
            DIG_HR_ONES:  nibble_c = snap_q[11:8];
            DIG_HR_TENS:  nibble_c = snap_q[15:12];
            default:      nibble_c = snap_q[3:0];
        endcase
    end

    bcd_to_7seg u_dec (
        .bcd   (nibble_c),
        .seg_c (dec_seg_c)
    );

    // Leading-zero suppression on the hour-tens digit; dp carries PM and colon
    always_comb begin
        seg_pat_c = dec_seg_c;
        if (digit_sel_q == DIG_HR_TENS && nibble_c == 4'd0) begin
            seg_pat_c = SEG_OFF;
        end
        dp_pat_c = 1'b1;
        if (digit_sel_q == DIG_MIN_ONES) begin
            dp_pat_c = ~pm;
        end else if (digit_sel_q == DIG_HR_ONES) begin
            dp_pat_c = ~colon_on;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        digit_sel_d  = digit_sel_q;
        snap_d       = snap_q;
        seg_d        = seg_q;
        dp_d         = dp_q;
        frame_done_d = 1'b0;
        frozen_d     = frozen_q;

        if (!en) begin
            seg_d    = SEG_OFF;
            dp_d     = 1'b1;
            frozen_d = 1'b1;
        end else begin
            frozen_d = 1'b0;
            case (state_q)
                BLANK: begin
                    seg_d = SEG_OFF;
                    dp_d  = 1'b1;
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = SHOW;
                        seg_d   = seg_pat_c;
                        dp_d    = dp_pat_c;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == DIGIT_LAST) begin
                        cnt_d       = '0;
                        state_d     = BLANK;
                        seg_d       = SEG_OFF;
                        dp_d        = 1'b1;
                        digit_sel_d = digit_sel_q + 2'd1;
                        if (digit_sel_q == DIG_HR_TENS) begin
                            snap_d       = digits;
                            frame_done_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        // Pattern was blanked by a pause; restore it on resume
                        if (frozen_q) begin
                            seg_d = seg_pat_c;
                            dp_d  = dp_pat_c;
                        end
                    end
                end
                default: begin
                    state_d = BLANK;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= BLANK;
            cnt_q        <= '0;
            digit_sel_q  <= DIG_MIN_ONES;
            snap_q       <= digits;
            seg_q        <= SEG_OFF;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
            frozen_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            digit_sel_q  <= digit_sel_d;
            snap_q       <= snap_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_done_q <= frame_done_d;
            frozen_q     <= frozen_d;
        end
    end

    assign digit_sel  = digit_sel_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_done = frame_done_q;

endmodule
